uart_tx_framed: RTL and testbench

UART_TX_FRAMED -- requirements
Module: uart_tx_framed

---
 rtl/uart_tx_framed.sv | 250 +++++++++++++++++++++++++
 tb/tb_uart_tx_framed.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_framed.sv
// Framed UART transmitter: AXI-Stream style input FIFO feeding a start/data/parity/stop serializer.
// Optional parity generation is enabled by defining UART_TX_PARITY_EN.
module uart_tx_framed #(
   parameter int DATA_WIDTH = 8,
   parameter int FIFO_DEPTH = 16
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic [DATA_WIDTH-1:0]         s_axis_tdata,
   input  logic                          s_axis_tvalid,
   output logic                          s_axis_tready,
   output logic                          txd,
   output logic                          busy,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
   input  logic [15:0]                   prescale,
   input  logic [3:0]                    cfg_data_bits,
   input  logic [1:0]                    cfg_parity,
   input  logic                          cfg_stop2
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = AW + 1;
   localparam int PW = 19;  // prescale * 8 needs three extra bits

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_START  = 3'd1,
      S_DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
      S_PARITY = 3'd3,
`endif
      S_STOP   = 3'd4
   } state_t;

   // ------------------------------------------------------------------
   // Transmit FIFO
   // ------------------------------------------------------------------
   logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
   logic [AW-1:0]         wr_ptr;
   logic [AW-1:0]         rd_ptr;
   logic [CW-1:0]         count;
   logic                  ready_en;
   logic                  push;
   logic                  fifo_pop;
   logic                  fifo_empty;

   assign fifo_empty    = (count == '0);
   assign s_axis_tready = ready_en && (count < CW'(FIFO_DEPTH));
   assign push          = s_axis_tvalid && s_axis_tready;
   assign fifo_count    = count;

   // ready_en keeps tready low through reset and raises it on the first edge after release
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ready_en <= 1'b0;
      end else begin
         // NOTE: sequential state always uses non-blocking assignment so all flops update together.
         ready_en <= 1'b1;
      end
   end

   // NOTE: the storage array has no reset; only pointers and count define validity, which keeps it RAM-mappable.
   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= s_axis_tdata;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + AW'(1);
         end
         if (fifo_pop) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
         case ({push, fifo_pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

   // ------------------------------------------------------------------
   // Frame parameters captured at the start of each frame
   // ------------------------------------------------------------------
   logic [15:0]           ps_eff;
   logic [PW-1:0]         period_eff;
   logic [3:0]            nbits_eff;

   assign ps_eff     = (prescale == 16'd0) ? 16'd1 : prescale;
   assign period_eff = {ps_eff, 3'b000};
   assign nbits_eff  = ((cfg_data_bits < 4'd5) || (cfg_data_bits > 4'(DATA_WIDTH)))
                       ? 4'(DATA_WIDTH) : cfg_data_bits;

`ifdef UART_TX_PARITY_EN
   logic par_en_eff;
   logic par_bit_eff;

   function automatic logic xor_low_bits(input logic [DATA_WIDTH-1:0] d, input logic [3:0] n);
      logic p;
      p = 1'b0;
      for (int i = 0; i < DATA_WIDTH; i++) begin
         if (4'(i) < n) begin
            p = p ^ d[i];
         end
      end
      return p;
   endfunction

   // 01 = even, 10 = odd; 00 and 11 both mean no parity bit
   assign par_en_eff  = cfg_parity[0] ^ cfg_parity[1];
   assign par_bit_eff = xor_low_bits(mem[rd_ptr], nbits_eff) ^ cfg_parity[1];
`else
   logic unused_cfg_parity;
   assign unused_cfg_parity = ^cfg_parity;
`endif

   // ------------------------------------------------------------------
   // Serializer FSM
   // ------------------------------------------------------------------
   state_t                state;
   state_t                state_next;
   logic [PW-1:0]         baud_cnt;
   logic [PW-1:0]         period_r;
   logic [3:0]            bit_idx;
   logic [3:0]            nbits_r;
   logic                  stop2_r;
   logic                  stop_idx;
   logic [DATA_WIDTH-1:0] shreg;
   logic                  tick;
   logic                  last_data;
   logic                  last_stop;
`ifdef UART_TX_PARITY_EN
   logic                  par_en_r;
   logic                  par_bit_r;
`endif

   assign tick      = (baud_cnt == '0);
   assign last_data = (bit_idx == nbits_r - 4'd1);
   assign last_stop = (stop_idx == stop2_r);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= S_IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      // NOTE: default assignment first so every path drives state_next and no latch is inferred.
      state_next = state;
      case (state)
         S_IDLE: begin
            if (!fifo_empty) begin
               state_next = S_START;
            end
         end
         S_START: begin
            if (tick) begin
               state_next = S_DATA;
            end
         end
         S_DATA: begin
            if (tick && last_data) begin
`ifdef UART_TX_PARITY_EN
               state_next = par_en_r ? S_PARITY : S_STOP;
`else
               state_next = S_STOP;
`endif
            end
         end
`ifdef UART_TX_PARITY_EN
         S_PARITY: begin
            if (tick) begin
               state_next = S_STOP;
            end
         end
`endif
         S_STOP: begin
            if (tick && last_stop) begin
               state_next = fifo_empty ? S_IDLE : S_START;
            end
         end
         default: state_next = S_IDLE;
      endcase
   end

   always_comb begin
      // every entry into START consumes one FIFO word
      fifo_pop = (state != S_START) && (state_next == S_START);
      busy     = !fifo_empty || (state != S_IDLE);
      case (state)
         S_START:  txd = 1'b0;
         S_DATA:   txd = shreg[0];
`ifdef UART_TX_PARITY_EN
         S_PARITY: txd = par_bit_r;
`endif
         default:  txd = 1'b1;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         baud_cnt  <= '0;
         period_r  <= '0;
         bit_idx   <= '0;
         nbits_r   <= '0;
         stop2_r   <= 1'b0;
         stop_idx  <= 1'b0;
         shreg     <= '0;
`ifdef UART_TX_PARITY_EN
         par_en_r  <= 1'b0;
         par_bit_r <= 1'b0;
`endif
      end else if (fifo_pop) begin
         baud_cnt  <= period_eff - PW'(1);
         period_r  <= period_eff;
         bit_idx   <= '0;
         nbits_r   <= nbits_eff;
         stop2_r   <= cfg_stop2;
         stop_idx  <= 1'b0;
         shreg     <= mem[rd_ptr];
`ifdef UART_TX_PARITY_EN
         par_en_r  <= par_en_eff;
         par_bit_r <= par_bit_eff;
`endif
      end else if (state != S_IDLE) begin
         if (tick) begin
            baud_cnt <= period_r - PW'(1);
            if (state == S_DATA) begin
               shreg   <= shreg >> 1;
               bit_idx <= bit_idx + 4'd1;
            end
            if (state == S_STOP) begin
               stop_idx <= stop_idx + 1'b1;
            end
         end else begin
            baud_cnt <= baud_cnt - PW'(1);
         end
      end
   end

endmodule

// File: tb/tb_uart_tx_framed.sv
// Scoreboard bench for uart_tx_framed: expected line waveforms are queued at word acceptance
// and a free-running monitor compares every cycle of each frame on txd.
`timescale 1ns/1ps
module tb_uart_tx_framed;

   localparam int DW    = 8;
   localparam int DEPTH = 16;
   localparam int CW    = $clog2(DEPTH) + 1;

   logic          clk;
   logic          rst_n;
   logic [DW-1:0] s_axis_tdata;
   logic          s_axis_tvalid;
   logic          s_axis_tready;
   logic          txd;
   logic          busy;
   logic [CW-1:0] fifo_count;
   logic [15:0]   prescale;
   logic [3:0]    cfg_data_bits;
   logic [1:0]    cfg_parity;
   logic          cfg_stop2;

   uart_tx_framed #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .s_axis_tdata  (s_axis_tdata),
      .s_axis_tvalid (s_axis_tvalid),
      .s_axis_tready (s_axis_tready),
      .txd           (txd),
      .busy          (busy),
      .fifo_count    (fifo_count),
      .prescale      (prescale),
      .cfg_data_bits (cfg_data_bits),
      .cfg_parity    (cfg_parity),
      .cfg_stop2     (cfg_stop2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [15:0] lv;   // line level for each bit slot, start bit first
      int          nb;   // number of bit slots in the frame
      int          per;  // clk cycles per bit slot
   } frame_t;

   frame_t sb[$];
   int     start_cyc[$];
   int     errors      = 0;
   int     checks      = 0;
   int     frames_seen = 0;
   int     ncyc        = 0;
   logic   mon_abort   = 1'b0;
   logic   in_frame    = 1'b0;

   always @(posedge clk) ncyc <= ncyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Reference frame built from the line protocol rules using the configuration at acceptance time.
   function automatic frame_t make_frame(input logic [DW-1:0] w);
      frame_t f;
      int     n;
      int     k;
      logic   p;
      n = ((cfg_data_bits < 5) || (cfg_data_bits > DW)) ? DW : int'(cfg_data_bits);
      f.lv = '1;
      f.lv[0] = 1'b0;
      k = 1;
      p = 1'b0;
      for (int i = 0; i < n; i++) begin
         f.lv[k] = w[i];
         p = p ^ w[i];
         k++;
      end
`ifdef UART_TX_PARITY_EN
      if (cfg_parity == 2'b01) begin
         f.lv[k] = p;
         k++;
      end else if (cfg_parity == 2'b10) begin
         f.lv[k] = ~p;
         k++;
      end
`endif
      f.lv[k] = 1'b1;
      k++;
      if (cfg_stop2) begin
         f.lv[k] = 1'b1;
         k++;
      end
      f.nb  = k;
      f.per = ((prescale == 0) ? 1 : int'(prescale)) * 8;
      return f;
   endfunction

   // Monitor: a low line while idle marks the first cycle of a start bit.
   initial begin
      frame_t f;
      int     bad;
      logic   aborted;
      forever begin
         @(negedge clk);
         if (rst_n && !mon_abort && txd === 1'b0) begin
            if (sb.size() == 0) begin
               check("spurious_start_words_queued", 32'(sb.size()), 32'd1);
               while (txd === 1'b0) @(negedge clk);
            end else begin
               f = sb.pop_front();
               start_cyc.push_back(ncyc);
               frames_seen++;
               in_frame = 1'b1;
               aborted  = 1'b0;
               for (int b = 0; b < f.nb; b++) begin
                  bad = 0;
                  for (int c = 0; c < f.per; c++) begin
                     if (b != 0 || c != 0) @(negedge clk);
                     if (mon_abort || !rst_n) begin
                        aborted = 1'b1;
                        break;
                     end
                     if (txd !== f.lv[b]) bad++;
                  end
                  if (aborted) break;
                  check($sformatf("frame%0d_bit%0d_wrong_cycles", frames_seen, b), 32'(bad), 32'd0);
               end
               in_frame = 1'b0;
            end
         end
      end
   end

   task automatic push_word(input logic [DW-1:0] w);
      int n;
      n = 0;
      s_axis_tdata  = w;
      s_axis_tvalid = 1'b1;
      while (s_axis_tready !== 1'b1 && n < 5000) begin
         @(negedge clk);
         n++;
      end
      if (n >= 5000) begin
         check("push_tready_timeout", 32'(n), 32'd0);
         s_axis_tvalid = 1'b0;
         return;
      end
      sb.push_back(make_frame(w));
      @(posedge clk);
      @(negedge clk);
      s_axis_tvalid = 1'b0;
   endtask

   task automatic drain(input int budget);
      int n;
      n = 0;
      while ((sb.size() != 0 || in_frame || busy) && n < budget) begin
         @(negedge clk);
         n++;
      end
      check("drain_within_budget", 32'(n < budget), 32'd1);
   endtask

   initial begin
      int busy_n;
      int f0;
      logic txd_second;

      rst_n         = 1'b0;
      s_axis_tdata  = '0;
      s_axis_tvalid = 1'b0;
      prescale      = 16'd1;
      cfg_data_bits = 4'd8;
      cfg_parity    = 2'b00;
      cfg_stop2     = 1'b0;

      // reset state and tready release
      repeat (3) @(negedge clk);
      check("rst_txd", 32'(txd), 32'd1);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_tready", 32'(s_axis_tready), 32'd0);
      check("rst_fifo_count", 32'(fifo_count), 32'd0);
      rst_n = 1'b1;
      #1;
      check("tready_before_first_edge", 32'(s_axis_tready), 32'd0);
      @(negedge clk);
      check("tready_after_first_edge", 32'(s_axis_tready), 32'd1);

      // 8N1, prescale 1, 0x55: one-cycle latency to start bit, busy spans the frame
      push_word(8'h55);
      check("txd_idle_cycle_after_write", 32'(txd), 32'd1);
      check("busy_on_write", 32'(busy), 32'd1);
      busy_n     = 0;
      txd_second = 1'b1;
      while (busy && busy_n < 1000) begin
         if (busy_n == 1) txd_second = txd;
         busy_n++;
         @(negedge clk);
      end
      check("txd_low_one_cycle_later", 32'(txd_second), 32'd0);
      check("busy_cycles_8n1_p1", 32'(busy_n), 32'd81);
      drain(200);

`ifdef UART_TX_PARITY_EN
      cfg_parity = 2'b01;
      push_word(8'h07);
      drain(300);
      cfg_parity = 2'b10;
      push_word(8'h07);
      drain(300);
      cfg_parity = 2'b00;
`endif

      // 7 data bits, two stops; config changed mid-frame must not affect the frame
      cfg_data_bits = 4'd7;
      cfg_stop2     = 1'b1;
      push_word(8'hC1);
      repeat (3) @(negedge clk);
      cfg_data_bits = 4'd8;
      cfg_stop2     = 1'b0;
      prescale      = 16'd3;
      drain(300);

      // continuous stream of 17 words into a 16-deep FIFO, back-to-back frames
      prescale = 16'd4;
      start_cyc.delete();
      f0 = frames_seen;
      for (int i = 0; i < 17; i++) begin
         push_word(DW'(i));
         check($sformatf("stream_fifo_count_w%0d", i), 32'(fifo_count), (i == 0) ? 32'd1 : 32'(i));
      end
      check("stream_full_tready", 32'(s_axis_tready), 32'd0);
      drain(17 * 320 + 200);
      check("stream_frames", 32'(frames_seen - f0), 32'd17);
      for (int i = 1; i < start_cyc.size(); i++) begin
         check($sformatf("stream_gap_%0d", i), 32'(start_cyc[i] - start_cyc[i-1]), 32'd320);
      end

      // reset in the middle of data bit 3, with a second word waiting in the FIFO
      prescale = 16'd2;
      push_word(8'hA5);
      push_word(8'h3C);
      repeat (72) @(negedge clk);
      #2;
      rst_n     = 1'b0;
      mon_abort = 1'b1;
      #1;
      check("midframe_rst_txd", 32'(txd), 32'd1);
      check("midframe_rst_busy", 32'(busy), 32'd0);
      check("midframe_rst_fifo_count", 32'(fifo_count), 32'd0);
      check("midframe_rst_tready", 32'(s_axis_tready), 32'd0);
      sb.delete();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      mon_abort = 1'b0;
      repeat (20) @(negedge clk);
      check("post_rst_fifo_count", 32'(fifo_count), 32'd0);
      check("post_rst_busy", 32'(busy), 32'd0);
      push_word(8'h96);
      drain(400);

      // randomized configurations, changed only while the transmitter is idle
      for (int g = 0; g < 6; g++) begin
         prescale      = 16'($urandom_range(0, 3));
         cfg_data_bits = 4'($urandom_range(0, 15));
         cfg_parity    = 2'($urandom_range(0, 3));
         cfg_stop2     = 1'($urandom_range(0, 1));
         for (int j = 0; j < 4; j++) begin
            repeat ($urandom_range(0, 20)) @(negedge clk);
            push_word(DW'($urandom));
         end
         drain(4 * 13 * 24 + 200);
      end

      check("final_busy", 32'(busy), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
